// File: rtl/serial_subtractor_4.sv
// Bit-serial unsigned subtractor: D = (X - Y) mod 2^W, B = borrow out (X < Y).
// One bit per clock, LSB first. The result and borrow are published only on completion.
module serial_subtractor_4 #(
    parameter int W = 4
) (
    input  logic         clk1,
    input  logic         rst1,
    input  logic         start,
    input  logic [W-1:0] X,
    input  logic [W-1:0] Y,
    output logic [W-1:0] D,
    output logic         B,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   r_q, r_d;
    logic [W-1:0]   d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           bor_q, bor_d;
    logic           b_q, b_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           xb, yb, diff_bit, bor_next, last_bit;
    logic [W-1:0]   r_shift;

    always_comb begin
        xb       = x_q[0];
        yb       = y_q[0];
        diff_bit = xb ^ yb ^ bor_q;
        bor_next = (~xb & yb) | (~(xb ^ yb) & bor_q);
        last_bit = (cnt_q == CW'(W - 1));
        // Each new difference bit enters at the MSB so bit 0 ends up at the bottom.
        r_shift  = {diff_bit, r_q[W-1:1]};

        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        bor_d   = bor_q;
        b_d     = b_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = X;
                    y_d     = Y;
                    r_d     = '0;
                    cnt_d   = '0;
                    bor_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                x_d   = x_q >> 1;
                y_d   = y_q >> 1;
                r_d   = r_shift;
                bor_d = bor_next;
                cnt_d = cnt_q + CW'(1);
                if (last_bit) begin
                    d_d     = r_shift;
                    b_d     = bor_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst1) begin
        if (rst1) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            bor_q   <= bor_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign D    = d_q;
    assign B    = b_q;
    assign busy = busy_q;
    assign done = done_q;

    // With W >= 2 a completion can never follow another on the next edge.
    a_done_single: assert property (@(posedge clk1) disable iff (rst1) done |=> !done);
    a_done_idle:   assert property (@(posedge clk1) disable iff (rst1) !(done && busy));

endmodule
